// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo enqueue arbiter.
//   arb_state_e : grant lock state (only used when FIFO_ARB_BURST_EN is defined)
//   N_REQ_MAX   : largest supported requester count
//   BURST_CNT_W : width of the burst beat counter
//   wrap_inc    : modulo-n increment of a requester index
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

    localparam int unsigned N_REQ_MAX   = 16;
    localparam int unsigned BURST_CNT_W = 4;

    // Explicit compare instead of '%' so non-power-of-2 counts wrap correctly.
    function automatic logic [BURST_CNT_W-1:0] wrap_inc(input logic [BURST_CNT_W-1:0] ptr,
                                                        input int unsigned n);
        return (ptr == BURST_CNT_W'(n - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_enq_arbiter_if.sv
// Bundle between N_REQ producers, the arbiter and a shared fifo enqueue port.
//   req_valid/req_data/req_ready : per-requester handshake (requester i at slice i)
//   valid_enq/data_enq/ready_enq : fifo enqueue handshake
//   grant_id                     : index of the current grant, 0 when nothing is valid
// Modports: master = arbiter side, slave = producers + fifo side.
interface fifo_enq_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned ID_WIDTH = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        valid_enq;
    logic [DATA_WIDTH-1:0]       data_enq;
    logic                        ready_enq;
    logic [ID_WIDTH-1:0]         grant_id;

    modport master (
        input  req_valid, req_data, ready_enq,
        output req_ready, valid_enq, data_enq, grant_id
    );

    modport slave (
        output req_valid, req_data, ready_enq,
        input  req_ready, valid_enq, data_enq, grant_id
    );
endinterface

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set bit of req searching start, start+1, ...
// wrapping N-1 -> 0.
//   req     : request vector
//   start   : highest-priority index this cycle
//   gnt_oh  : one-hot grant (zero when no request)
//   gnt_idx : grant index (zero when no request)
//   any     : at least one request present
module rr_prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         gnt_oh,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);
    localparam int unsigned IW = $clog2(N);

    int unsigned   idx;
    logic [IW-1:0] idx_w;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(start) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = IW'(idx);
            if (!any && req[idx_w]) begin
                any            = 1'b1;
                gnt_oh[idx_w]  = 1'b1;
                gnt_idx        = idx_w;
            end
        end
    end
endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one fifo enqueue port among N_REQ requesters.
// Grant is combinational; the only state is the round-robin pointer, plus the
// lock state, owner and beat counter when FIFO_ARB_BURST_EN is defined (an owner
// then keeps the grant for up to MAX_BURST beats while it stays valid).
//   clk    : clock, rising edge
//   rst_sH : synchronous active-high reset; forces all outputs to zero while high
//   bus    : fifo_enq_arbiter_if master modport (requester + fifo handshakes)
module fifo_enq_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                rst_sH,
    fifo_enq_arbiter_if.master  bus
);
    import fifo_arb_pkg::*;

    localparam int unsigned ID_WIDTH = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > N_REQ_MAX || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_param
        $error("fifo_enq_arbiter: N_REQ or MAX_BURST out of range");
    end

    function automatic logic [ID_WIDTH-1:0] inc_ptr(input logic [ID_WIDTH-1:0] p);
        return ID_WIDTH'(wrap_inc(BURST_CNT_W'(p), N_REQ));
    endfunction

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   start_ptr;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [N_REQ-1:0]      gnt_oh;
    logic                  any;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] data_mux;

    assign xfer = any & bus.ready_enq;

`ifdef FIFO_ARB_BURST_EN
    arb_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]    owner_q, owner_d;
    logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
    logic                   owner_hold;

    assign owner_hold = (state_q == ARB_LOCK) && bus.req_valid[owner_q];

    // Starting the search at the owner forces the grant to it; once it drops,
    // searching from owner+1 gives the same-cycle round-robin fallback.
    always_comb begin
        start_ptr = rr_ptr_q;
        if (state_q == ARB_LOCK) begin
            start_ptr = owner_hold ? owner_q : inc_ptr(owner_q);
        end
    end
`else
    assign start_ptr = rr_ptr_q;
`endif

    rr_prio_enc #(.N(N_REQ)) u_enc (
        .req     (bus.req_valid),
        .start   (start_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        data_mux = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            data_mux = data_mux | ({DATA_WIDTH{gnt_oh[i]}} & bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        if (rst_sH) begin
            bus.valid_enq = 1'b0;
            bus.req_ready = '0;
            bus.grant_id  = '0;
            bus.data_enq  = '0;
        end else begin
            bus.valid_enq = any;
            bus.req_ready = gnt_oh & {N_REQ{bus.ready_enq}};
            bus.grant_id  = gnt_idx;
            bus.data_enq  = data_mux;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer) begin
                    if (MAX_BURST > 1) begin
                        state_d = ARB_LOCK;
                        owner_d = gnt_idx;
                        cnt_d   = BURST_CNT_W'(1);
                    end else begin
                        rr_ptr_d = inc_ptr(gnt_idx);
                    end
                end
            end
            ARB_LOCK: begin
                if (!owner_hold) begin
                    // Owner left: a fallback beat this cycle moves the pointer past it.
                    state_d  = ARB_IDLE;
                    cnt_d    = '0;
                    rr_ptr_d = xfer ? inc_ptr(gnt_idx) : inc_ptr(owner_q);
                end else if (xfer) begin
                    if (cnt_q + 1'b1 == BURST_CNT_W'(MAX_BURST)) begin
                        state_d  = ARB_IDLE;
                        cnt_d    = '0;
                        rr_ptr_d = inc_ptr(owner_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sH) begin
            rr_ptr_q <= '0;
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = inc_ptr(gnt_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sH) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter: two instances (N_REQ=4 with MAX_BURST=3, and
// N_REQ=3 with MAX_BURST=1), directed literal checks plus randomized traffic
// compared every cycle against a queue-free index-arithmetic reference model.
// Honours FIFO_ARB_BURST_EN the same way the design does.
module tb_fifo_enq_arbiter;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_enq_arbiter_if #(.N_REQ(4), .DATA_WIDTH(DW)) b0 ();
    fifo_enq_arbiter_if #(.N_REQ(3), .DATA_WIDTH(DW)) b1 ();

    fifo_enq_arbiter #(.DATA_WIDTH(DW), .N_REQ(4), .MAX_BURST(3)) dut0 (
        .clk(clk), .rst_sH(rst), .bus(b0)
    );
    fifo_enq_arbiter #(.DATA_WIDTH(DW), .N_REQ(3), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_sH(rst), .bus(b1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_n  [2] = '{4, 3};
    int unsigned m_mb [2] = '{3, 1};
    int unsigned m_rr [2] = '{0, 0};
    int unsigned m_own[2] = '{0, 0};
    int unsigned m_cnt[2] = '{0, 0};
    bit          m_lock[2] = '{1'b0, 1'b0};
    bit          check_en = 1'b0;

    function automatic int pick(input logic [3:0] v, input int unsigned start, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return int'((start + k) % n);
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic [3:0] v, input logic [127:0] data,
                              input logic rdy, input logic ov, input logic [31:0] od,
                              input logic [3:0] ordy, input logic [3:0] ogid);
        int unsigned n;
        int unsigned st;
        int          g;
        bit          own;
        bit          xfer;
        logic [31:0] ed;
        n = m_n[d];
        if (rst) begin
            chk($sformatf("dut%0d rst valid_enq", d), ov, 0);
            chk($sformatf("dut%0d rst req_ready", d), ordy, 0);
            chk($sformatf("dut%0d rst grant_id", d), ogid, 0);
            chk($sformatf("dut%0d rst data_enq", d), od, 0);
            m_rr[d] = 0; m_own[d] = 0; m_cnt[d] = 0; m_lock[d] = 1'b0;
            return;
        end
        own = m_lock[d] && v[m_own[d]];
        st  = own ? m_own[d] : (m_lock[d] ? (m_own[d] + 1) % n : m_rr[d]);
        g   = pick(v, st, n);
        if (g < 0) begin
            chk($sformatf("dut%0d valid_enq", d), ov, 0);
            chk($sformatf("dut%0d req_ready", d), ordy, 0);
            chk($sformatf("dut%0d grant_id", d), ogid, 0);
            chk($sformatf("dut%0d data_enq", d), od, 0);
        end else begin
            ed = data[g*32 +: 32];
            chk($sformatf("dut%0d valid_enq", d), ov, 1);
            chk($sformatf("dut%0d req_ready", d), ordy, rdy ? (1 << g) : 0);
            chk($sformatf("dut%0d grant_id", d), ogid, g);
            chk($sformatf("dut%0d data_enq", d), od, ed);
        end
        xfer = (g >= 0) && rdy;
`ifdef FIFO_ARB_BURST_EN
        if (m_lock[d]) begin
            if (!own) begin
                m_lock[d] = 1'b0; m_cnt[d] = 0;
                m_rr[d] = xfer ? (g + 1) % n : (m_own[d] + 1) % n;
            end else if (xfer) begin
                if (m_cnt[d] + 1 == m_mb[d]) begin
                    m_lock[d] = 1'b0; m_cnt[d] = 0; m_rr[d] = (m_own[d] + 1) % n;
                end else begin
                    m_cnt[d]++;
                end
            end
        end else if (xfer) begin
            if (m_mb[d] > 1) begin
                m_lock[d] = 1'b1; m_own[d] = g; m_cnt[d] = 1;
            end else begin
                m_rr[d] = (g + 1) % n;
            end
        end
`else
        if (xfer) m_rr[d] = (g + 1) % n;
`endif
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            model_step(0, b0.req_valid, b0.req_data, b0.ready_enq, b0.valid_enq,
                       b0.data_enq, b0.req_ready, 4'(b0.grant_id));
            model_step(1, {1'b0, b1.req_valid}, {32'b0, b1.req_data}, b1.ready_enq,
                       b1.valid_enq, b1.data_enq, {1'b0, b1.req_ready}, 4'(b1.grant_id));
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
    endtask

    int exp_fair[8];
    int exp_after_stall;
    logic [31:0] r;

    initial begin
`ifdef FIFO_ARB_BURST_EN
        exp_fair        = '{0, 0, 0, 1, 1, 1, 2, 2};
        exp_after_stall = 2;
`else
        exp_fair        = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_after_stall = 3;
`endif
        rst          = 1'b1;
        b0.req_valid = 4'b1111;
        b0.req_data  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
        b0.ready_enq = 1'b1;
        b1.req_valid = '0;
        b1.req_data  = '0;
        b1.ready_enq = 1'b1;
        check_en     = 1'b1;

        // reset holds outputs low even with all requests and a ready fifo
        @(negedge clk);
        chk("reset valid_enq", b0.valid_enq, 0);
        chk("reset req_ready", b0.req_ready, 0);
        next_cyc();
        rst = 1'b0;

        // fairness: all valid, fifo always ready
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("fair grant_id[%0d]", i), b0.grant_id, exp_fair[i]);
            next_cyc();
        end

        // stall on requester 2, then release
        do_reset();
        b0.req_valid = 4'b1100;
        b0.ready_enq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall grant_id", b0.grant_id, 2);
            chk("stall req_ready", b0.req_ready, 0);
            next_cyc();
        end
        b0.ready_enq = 1'b1;
        @(negedge clk);
        chk("stall release req_ready", b0.req_ready, 4'b0100);
        chk("stall release data_enq", b0.data_enq, 32'h2222_0002);
        next_cyc();
        @(negedge clk);
        chk("after stall grant_id", b0.grant_id, exp_after_stall);

        // wrap/sparse on the 3-requester instance
        next_cyc();
        do_reset();
        b0.req_valid = '0;
        b1.req_data  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        b1.req_valid = 3'b010;
        @(negedge clk);
        chk("wrap setup grant_id", b1.grant_id, 1);
        next_cyc();
        b1.req_valid = 3'b101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("wrap grant_id[%0d]", i), b1.grant_id, (i % 2 == 0) ? 2 : 0);
            chk($sformatf("wrap data_enq[%0d]", i), b1.data_enq,
                (i % 2 == 0) ? 32'hCCCC_0002 : 32'hAAAA_0000);
            next_cyc();
        end
        b1.req_valid = '0;

        // owner drops after one beat: requester 1 granted in the same cycle
        do_reset();
        b0.req_valid = 4'b1111;
        @(negedge clk);
        chk("drop first grant_id", b0.grant_id, 0);
        next_cyc();
        b0.req_valid = 4'b1110;
        @(negedge clk);
        chk("drop fallback grant_id", b0.grant_id, 1);
        next_cyc();

        // randomized traffic, including resets mid-burst and mid-stall
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            r = $urandom & $urandom;
            b0.req_valid = ~r[3:0];
            b1.req_valid = ~r[6:4];
            if ($urandom_range(0, 9) == 0) b0.req_valid = 4'(1 << $urandom_range(0, 3));
            b0.req_data  = {$urandom, $urandom, $urandom, $urandom};
            b1.req_data  = {$urandom, $urandom, $urandom};
            b0.ready_enq = ($urandom_range(0, 3) != 0);
            b1.ready_enq = ($urandom_range(0, 3) != 0);
            next_cyc();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
